// File: rtl/tape_ram_bridge.sv
// rtl/tape_ram_bridge.sv - tape loader to RAM write bridge with capture FIFO and BASIC pointer patch
// Bytes are deduplicated by address, queued, written on free RAM slots, then pointers patched.
module tape_ram_bridge #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] PATCH_BASE = 16'h009C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_complete,
  input  logic        tape_autorun,
  input  logic        basic_file,
  input  logic        ram_slot,
  output logic        in_ready,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        busy,
  output logic        overflow,
  output logic        done,
  output logic        autorun_go,
  output logic [15:0] bytes_written
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_PATCH, S_AUTORUN, S_DONE} state_t;
  state_t state;

  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   last_addr;
  logic [15:0]   max_addr;
  logic          complete_q, basic_q, autorun_flag;
  logic [2:0]    patch_idx;

  logic full, empty, accept, push, pop, drop, patch_we, complete_rise;
  logic [15:0] end_addr;

  assign full          = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign complete_rise = tape_complete && !complete_q;
  // In IDLE any byte is the first; afterwards only a new address counts as a new byte.
  assign accept   = tape_wr && ((state == S_IDLE) ||
                    (((state == S_STREAM) || (state == S_DRAIN)) && (tape_addr != last_addr)));
  assign pop      = ram_slot && !empty && !reset;
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign patch_we = (state == S_PATCH) && ram_slot && !reset;
  assign end_addr = max_addr + 16'd1;
  assign in_ready = !full;

  always_comb begin
    ram_we   = pop || patch_we;
    ram_addr = 16'h0000;
    ram_din  = 8'h00;
    if (pop) begin
      ram_addr = fifo_addr[rd_ptr];
      ram_din  = fifo_data[rd_ptr];
    end else if (patch_we) begin
      ram_addr = PATCH_BASE + {13'b0, patch_idx};
      ram_din  = patch_idx[0] ? end_addr[15:8] : end_addr[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      last_addr     <= 16'h0000;
      max_addr      <= 16'h0000;
      complete_q    <= 1'b0;
      basic_q       <= 1'b0;
      autorun_flag  <= 1'b0;
      patch_idx     <= 3'd0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
      autorun_go    <= 1'b0;
      bytes_written <= 16'h0000;
    end else begin
      complete_q <= tape_complete;
      if (accept) last_addr <= tape_addr;
      if (drop) overflow <= 1'b1;
      if (push) begin
        fifo_addr[wr_ptr] <= tape_addr;
        fifo_data[wr_ptr] <= tape_dout;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_STREAM;
            busy          <= 1'b1;
            autorun_flag  <= 1'b0;
            max_addr      <= 16'h0000;
            bytes_written <= 16'h0000;
          end else if (complete_rise) begin
            state        <= S_AUTORUN;
            busy         <= 1'b1;
            autorun_flag <= 1'b0;
          end
        end
        S_STREAM: begin
          if (tape_autorun) autorun_flag <= 1'b1;
          if (complete_rise) begin
            state   <= S_DRAIN;
            basic_q <= basic_file;
          end
        end
        S_DRAIN: begin
          if (tape_autorun) autorun_flag <= 1'b1;
          if (empty && !push) begin
            state     <= basic_q ? S_PATCH : S_AUTORUN;
            patch_idx <= 3'd0;
          end
        end
        S_PATCH: begin
          if (patch_we) begin
            patch_idx <= patch_idx + 3'd1;
            if (patch_idx == 3'd5) state <= S_AUTORUN;
          end
        end
        S_AUTORUN: begin
          // One extra AUTORUN cycle carries the go pulse so it precedes done.
          if (autorun_flag) begin
            autorun_go   <= 1'b1;
            autorun_flag <= 1'b0;
          end else begin
            autorun_go <= 1'b0;
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        S_DONE: begin
          if (!tape_complete) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Program bytes only; patch writes never go through the FIFO pop path.
      if (pop) begin
        bytes_written <= bytes_written + 16'd1;
        if (fifo_addr[rd_ptr] > max_addr) max_addr <= fifo_addr[rd_ptr];
      end
    end
  end

endmodule

// File: doc/tape_ram_bridge.md
TAPE_RAM_BRIDGE -- requirements
Module: tape_ram_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, capture FIFO entries; power of two, 4..64.
REQ-002 Parameter PATCH_BASE, default 16'h009C, first byte of the 6-byte BASIC pointer block (VARTAB/ARYTAB/STREND).
REQ-003 Ports (name  direction  width  meaning):
 clk  in  1  single system clock; all logic rising-edge.
 reset  in  1  synchronous, active-high reset.
 tape_wr  in  1  byte-valid level from the tape loader.
 tape_addr  in  16  target RAM address of the offered byte.
 tape_dout  in  8  offered byte.
 tape_complete  in  1  loader finished; level, stays high.
 tape_autorun  in  1  loader autorun pulse.
 basic_file  in  1  loaded file is BASIC (file type 8'h00); sampled when tape_complete rises.
 ram_slot  in  1  RAM free for one write this cycle.
 in_ready  out  1  FIFO can accept a byte.
 ram_we  out  1  RAM write strobe, one cycle.
 ram_addr  out  16  RAM write address.
 ram_din  out  8  RAM write data.
 busy  out  1  transfer in progress.
 overflow  out  1  sticky: byte lost to full FIFO.
 done  out  1  transfer, patch and autorun handling finished.
 autorun_go  out  1  one-cycle request to start the loaded program.
 bytes_written  out  16  count of program bytes written to RAM.

Function
REQ-004 Byte accepted in a cycle when tape_wr=1 and (first byte since reset/IDLE, or tape_addr differs from last accepted address); repeats of the same address are ignored.
REQ-005 Accepted byte pushed as {addr,data}; in_ready = FIFO not full.
REQ-006 Accepted byte while FIFO full: byte dropped, overflow set, stays set until reset.
REQ-007 Push and pop in the same cycle on a full FIFO: push is accepted (pop frees the slot); no overflow.
REQ-008 Pop occurs in a cycle with ram_slot=1 and FIFO non-empty: ram_we=1, ram_addr/ram_din = head entry, same cycle (registered outputs valid in the cycle after ram_slot sampled is NOT permitted; ram_we is combinational from ram_slot and registered FIFO head).
REQ-009 bytes_written increments per program-byte pop; wraps 16'hFFFF->0.
REQ-010 Track max_addr = highest program address popped.
REQ-011 States: IDLE, STREAM, DRAIN, PATCH, AUTORUN, DONE.
REQ-012 IDLE -> STREAM on first accepted byte; busy=1 in every state except IDLE and DONE.
REQ-013 STREAM -> DRAIN on tape_complete rising edge; latch basic_file and whether tape_autorun was seen (pulse captured into sticky flag at any time in STREAM/DRAIN).
REQ-014 Bytes still arriving in DRAIN are accepted per REQ-004.
REQ-015 DRAIN -> PATCH when FIFO empty and basic_file latched=1; -> AUTORUN when FIFO empty and basic_file=0.
REQ-016 PATCH writes six bytes, one per ram_slot, addresses PATCH_BASE..PATCH_BASE+5, data alternating low/high of (max_addr+1) mod 2^16; patch writes do not count in bytes_written.
REQ-017 PATCH -> AUTORUN after sixth write.
REQ-018 AUTORUN: if autorun flag set, autorun_go=1 for exactly one cycle; then -> DONE; otherwise -> DONE directly.
REQ-019 DONE: done=1, no RAM writes; returns to IDLE when tape_complete=0.
REQ-020 tape_complete rising while IDLE (empty file): IDLE -> AUTORUN, no patch, no RAM writes.
REQ-021 ram_we never asserted while ram_slot=0.

Reset
REQ-022 reset=1: state IDLE, FIFO empty, ram_we=0, ram_addr=0, ram_din=0, busy=0, overflow=0, done=0, autorun_go=0, bytes_written=0, max_addr=0, flags cleared; in_ready=1 the cycle after.
REQ-023 Reset mid-transfer discards FIFO contents; no further RAM writes until new bytes accepted.

Verification
REQ-024 Three bytes 0x501..0x503 = 11,22,33, ram_slot always 1, tape_complete, basic_file=0 -> three writes in order, bytes_written=3, done=1, no autorun_go.
REQ-025 tape_wr held 40 cycles with unique addresses, ram_slot=0 -> 16 accepted, overflow=1, in_ready=0; ram_slot=1 then writes exactly 16 bytes.
REQ-026 BASIC file 0x0501..0x0600, basic_file=1 -> after program, writes 9C..A1 = 01,06,01,06,01,06.
REQ-027 tape_autorun pulse during STREAM -> single-cycle autorun_go after final write, then done=1.
REQ-028 tape_wr held with unchanged address 10 cycles -> one byte written.
REQ-029 reset asserted with 5 bytes queued -> no ram_we afterwards, all outputs at reset values.
